pc_fetch: RTL

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/mips_pkg.sv | 23 ++
 rtl/pc_fetch_if.sv | 28 ++
 rtl/pc_fetch_next_pc.sv | 40 ++++
 rtl/pc_fetch.sv | 120 ++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch front end.
// Holds the next-PC select encodings, the fetch FSM state enum and the default reset PC.
// No logic; imported by pc_fetch, next_pc and the bench.
package mips_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

  // Next-PC select driven by the controller.
  typedef enum logic [1:0] {
    PCSEL_PLUS4  = 2'b00,
    PCSEL_BRANCH = 2'b01,
    PCSEL_JUMP   = 2'b10,
    PCSEL_REG    = 2'b11
  } pcsel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_EXEC  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_if.sv
// Instruction-memory request/response bundle.
// Ports: imem_req/imem_addr (fetch -> memory), imem_ready (accept), imem_valid/imem_rdata (response).
// master = fetch unit, slave = instruction memory.
interface pc_fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_valid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_valid,
    output imem_rdata
  );

endinterface

// File: rtl/pc_fetch_next_pc.sv
// Combinational next-PC selection: pc+4, branch, jump or register target.
// Ports: i_pc, i_instr, i_pcsel, i_jr_target in; o_next_pc, o_pc_plus4, o_misalign (reg target low bits set) out.
// Zero latency, no handshake; all arithmetic wraps modulo 2^32.
module next_pc
  import mips_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [31:0] i_instr,
  input  logic [1:0]  i_pcsel,
  input  logic [31:0] i_jr_target,
  output logic [31:0] o_next_pc,
  output logic [31:0] o_pc_plus4,
  output logic        o_misalign
);

  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_off;

  assign w_pc_plus4 = i_pc + 32'd4;
  // Sign-extended word offset, already scaled to bytes.
  assign w_br_off   = {{14{i_instr[15]}}, i_instr[15:0], 2'b00};
  assign o_pc_plus4 = w_pc_plus4;

  always_comb begin
    o_next_pc  = w_pc_plus4;
    o_misalign = 1'b0;
    case (pcsel_e'(i_pcsel))
      PCSEL_PLUS4:  o_next_pc = w_pc_plus4;
      PCSEL_BRANCH: o_next_pc = w_pc_plus4 + w_br_off;
      PCSEL_JUMP:   o_next_pc = {w_pc_plus4[31:28], i_instr[25:0], 2'b00};
      PCSEL_REG: begin
        // Low bits are dropped so fetch stays word aligned; the event is flagged instead.
        o_next_pc  = {i_jr_target[31:2], 2'b00};
        o_misalign = |i_jr_target[1:0];
      end
      default: o_next_pc = w_pc_plus4;
    endcase
  end

endmodule

// File: rtl/pc_fetch.sv
// Fetch FSM (IDLE/FETCH/WAIT/EXEC): issues imem requests, latches the instruction, strobes enable, advances pc.
// Ports: clk, reset, run, imem (master), pcsel/jr_target, dbg_retired_ld/val (counter preload); instr/op/func, enable, pc/pc_plus4, misalign, retired out.
// Min 3 cycles per instruction; req/addr held while imem_ready low, waits indefinitely for imem_valid, run low finishes the current instruction.
module pc_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  pc_fetch_if.master  imem,
  input  logic [1:0]  pcsel,
  input  logic [31:0] jr_target,
  input  logic        dbg_retired_ld,
  input  logic [31:0] dbg_retired_val,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic        enable,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misalign,
  output logic [31:0] retired
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic [31:0]  r_retired;
  logic         r_req;
  logic         r_enable;
  logic         r_misalign;

  logic [31:0]  w_next_pc;
  logic [31:0]  w_pc_plus4;
  logic         w_misalign_hit;

  next_pc u_next_pc (
    .i_pc        (r_pc),
    .i_instr     (r_instr),
    .i_pcsel     (pcsel),
    .i_jr_target (jr_target),
    .o_next_pc   (w_next_pc),
    .o_pc_plus4  (w_pc_plus4),
    .o_misalign  (w_misalign_hit)
  );

  // req and enable are registered alongside the state so they are glitch-free
  // and asserted exactly while the FSM sits in FETCH / EXEC respectively.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_instr    <= 32'd0;
      r_retired  <= 32'd0;
      r_req      <= 1'b0;
      r_enable   <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (run) begin
            r_state <= ST_FETCH;
            r_req   <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (imem.imem_ready) begin
            r_state <= ST_WAIT;
            r_req   <= 1'b0;
          end
        end
        ST_WAIT: begin
          // Only place imem_valid is honoured; stray responses elsewhere are dropped.
          if (imem.imem_valid) begin
            r_instr  <= imem.imem_rdata;
            r_state  <= ST_EXEC;
            r_enable <= 1'b1;
          end
        end
        ST_EXEC: begin
          r_enable  <= 1'b0;
          r_pc      <= w_next_pc;
          r_retired <= r_retired + 32'd1;
          if (w_misalign_hit) begin
            r_misalign <= 1'b1;
          end
          if (run) begin
            r_state <= ST_FETCH;
            r_req   <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_req    <= 1'b0;
          r_enable <= 1'b0;
        end
      endcase
      // Debug preload of the retire counter takes priority over the increment.
      if (dbg_retired_ld) begin
        r_retired <= dbg_retired_val;
      end
    end
  end

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_pc;
  assign instr          = r_instr;
  assign op             = r_instr[31:26];
  assign func           = r_instr[5:0];
  assign enable         = r_enable;
  assign pc             = r_pc;
  assign pc_plus4       = w_pc_plus4;
  assign misalign       = r_misalign;
  assign retired        = r_retired;

endmodule
